hb_interp_filter: RTL and testbench
===================================

# hb_interp_filter

Half-band 2× interpolation filter, the transmit-side counterpart of the half-band decimator in the ADC path. It accepts one signed 35-bit sample per input strobe and emits two output samples at twice the rate. It uses the same 7-tap Q30 half-band prototype (−54357298, 0, 316817548, 536870912, 316817548, 0, −54357298) in polyphase form, with a gain of 2 to restore unity passband gain after zero-stuffing. It sits between the DSP sample source and the higher-rate DAC-side stage.

## Interface
- `DW`, 35: data width of `dat_in` and `dat_out`.
- `CW`, 31: coefficient width, signed Q30.
- `clk` input 1: single clock.
- `rst` input 1: asynchronous, active-high reset.
- `clk_vld_in` input 1: input sample strobe; `dat_in` is accepted when high and `in_rdy` is high.
- `dat_in` input DW: signed input sample.
- `in_rdy` output 1: block can accept a sample this cycle.
- `clk_vld_out` output 1: one-cycle strobe; `dat_out` is new.
- `dat_out` output DW: signed interpolated sample.
- `drop_err` output 1: sticky; a strobe arrived while `in_rdy` was low.
- `sat_flag` output 1: pulses with `clk_vld_out` when `dat_out` was saturated.

## Operation
- Delay line `x0..x3` shifts on every accepted sample: `x0 <= dat_in`.
- Even phase: `y_e = (2·(−c0·(x0+x3) + c1·(x1+x2))) >>> 30`.
  - Taps are 36-bit sums.
  - Products are 67 bits; accumulate at 69 bits.
  - `>>>` is arithmetic (floor); no rounding.
- Odd phase: `y_o = x1` (centre tap 0.5 × gain 2, exact).
- FSM states:
  - IDLE: no output in flight. Transitions to PH0 on an accepted strobe.
  - PH0: `y_e` is registered into `dat_out`. Always transitions to PH1.
  - PH1: `y_o` is registered. Transitions to PH0 if a strobe is accepted in the same cycle, otherwise to IDLE.
- `in_rdy` is low only in PH0.
- A strobe in PH0 is dropped: no shift occurs and `drop_err` is set until reset.
- If a shift and the odd capture occur on the same edge, the odd capture uses the pre-shift `x1`.
- Reset, including mid-operation: all outputs and taps go to 0, the FSM goes to IDLE, and `drop_err` is cleared.
- Reset values: `in_rdy=1`, `clk_vld_out=0`, `dat_out=0`, `drop_err=0`, `sat_flag=0`.

## Timing
- A sample accepted in cycle T produces:
  - even output, `clk_vld_out=1` in cycle T+2;
  - odd output, `clk_vld_out=1` in cycle T+3.
- Minimum input spacing is 2 cycles. At that spacing `clk_vld_out` is continuously high, with outputs alternating even/odd.
- `in_rdy` is combinational from the state register only, with no path from `clk_vld_in`.

## Configuration
- `HB_INTERP_SAT_EN` defined:
  - `y_e` outside [−2^34, 2^34−1] clamps to that bound;
  - `sat_flag` pulses with the affected `clk_vld_out`.
- `HB_INTERP_SAT_EN` undefined:
  - `dat_out` takes the low DW bits (two's-complement wrap);
  - `sat_flag` is tied 0.
- `y_o` never saturates.

## Structure
- Shared package `hb_pkg`:
  - coefficient constants `HB_C0=54357298`, `HB_C1=316817548`, `HB_CC=536870912`;
  - `HB_SHIFT=30`;
  - FSM state enum.
- One sub-module, `hb_sat`: a parameterised signed width-reduction block (saturate or wrap under the macro, producing the flag). It is reusable by the decimator.

## Test plan
- Impulse `dat_in=1073741824`, then zeros (spacing 2) -> `dat_out` sequence:
  - −108714596, 0;
  - 633635096, 1073741824;
  - 633635096, 0;
  - −108714596, 0;
  - then 0s.
- DC `dat_in=1073741824` held, spacing 3 -> after 4 samples, even outputs 1049841000 and odd outputs 1073741824. `clk_vld_out` pattern: 2 high, 1 low.
- Strobe on consecutive cycles -> second sample dropped, `drop_err=1` stays high, and the delay line is unchanged by the dropped sample.
- Inputs −2^34, 2^34−1, 2^34−1, −2^34:
  - with `HB_INTERP_SAT_EN`: fourth even output = 17179869183 and `sat_flag=1`;
  - without it: low 35 bits of the full result and `sat_flag=0`.
- `rst` asserted between the even and odd output of a sample -> next cycle `clk_vld_out=0`, `dat_out=0`, `in_rdy=1`. A post-reset impulse reproduces scenario 1 exactly.
- Random samples, random spacing ≥2 -> output matches a bit-true polyphase model. Exactly 2 `clk_vld_out` pulses per accepted sample.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared constants and FSM state type for the half-band interpolator/decimator pair.
package hb_pkg;
    localparam int HB_C0    = 54357298;
    localparam int HB_C1    = 316817548;
    localparam int HB_CC    = 536870912;
    localparam int HB_SHIFT = 30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PH0,
        ST_PH1
    } hb_state_e;
endpackage

// File: rtl/hb_sat.sv
// Signed width reduction IW -> OW: clamps when HB_INTERP_SAT_EN is defined,
// otherwise keeps the low OW bits (two's-complement wrap) and never flags.
module hb_sat #(
    parameter int IW = 39,
    parameter int OW = 35
) (
    input  logic [IW-1:0] d_i,
    output logic [OW-1:0] q_o,
    output logic          sat_o
);
`ifdef HB_INTERP_SAT_EN
    localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        q_o   = d_i[OW-1:0];
        sat_o = 1'b0;
        if ($signed(d_i) > MAXV) begin
            q_o   = MAXV[OW-1:0];
            sat_o = 1'b1;
        end else if ($signed(d_i) < MINV) begin
            q_o   = MINV[OW-1:0];
            sat_o = 1'b1;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^d_i[IW-1:OW];
    assign q_o       = d_i[OW-1:0];
    assign sat_o     = 1'b0;
`endif
endmodule

// File: rtl/hb_interp_filter.sv
// Half-band 2x interpolator: one input sample yields an even (filtered) and an
// odd (centre-tap) output. Even-output saturation enabled by HB_INTERP_SAT_EN.
module hb_interp_filter
    import hb_pkg::*;
#(
    parameter int DW = 35,
    parameter int CW = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_vld_in,
    input  logic [DW-1:0] dat_in,
    output logic          in_rdy,
    output logic          clk_vld_out,
    output logic [DW-1:0] dat_out,
    output logic          drop_err,
    output logic          sat_flag
);
    localparam int TW = DW + 1;
    localparam int PW = TW + CW;
    localparam int AW = PW + 2;
    localparam int EW = AW - HB_SHIFT;
    localparam logic signed [CW-1:0] C0 = CW'(HB_C0);
    localparam logic signed [CW-1:0] C1 = CW'(HB_C1);

    hb_state_e             state_q, state_d;
    logic signed [DW-1:0]  x_q [4];
    logic                  accept;
    logic signed [TW-1:0]  tap_out, tap_in;
    logic signed [PW-1:0]  prod_out, prod_in;
    logic signed [AW-1:0]  acc;
    logic [EW-1:0]         ye_full;
    logic [DW-1:0]         ye;
    logic                  ye_sat;
    logic                  unused_lo;
    logic                  vld_q, sat_q, drop_q;
    logic [DW-1:0]         dat_q;

    assign in_rdy = (state_q != ST_PH0);
    assign accept = clk_vld_in & in_rdy;

    // Outer taps carry -c0, inner taps +c1; the x2 gain is folded in as a shift.
    assign tap_out  = TW'(x_q[0]) + TW'(x_q[3]);
    assign tap_in   = TW'(x_q[1]) + TW'(x_q[2]);
    assign prod_out = PW'(tap_out) * PW'(C0);
    assign prod_in  = PW'(tap_in) * PW'(C1);
    assign acc      = (AW'(prod_in) - AW'(prod_out)) <<< 1;
    assign ye_full  = acc[AW-1:HB_SHIFT];
    assign unused_lo = ^acc[HB_SHIFT-1:0];

    hb_sat #(.IW(EW), .OW(DW)) u_sat (
        .d_i   (ye_full),
        .q_o   (ye),
        .sat_o (ye_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (clk_vld_in) state_d = ST_PH0;
            ST_PH0:  state_d = ST_PH1;
            ST_PH1:  state_d = clk_vld_in ? ST_PH0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Odd capture reads x_q[1] before any same-edge shift lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
            drop_q <= 1'b0;
            dat_q  <= '0;
            for (int i = 0; i < 4; i++) x_q[i] <= '0;
        end else begin
            vld_q <= 1'b0;
            sat_q <= 1'b0;
            if (state_q == ST_PH0) begin
                vld_q <= 1'b1;
                dat_q <= ye;
                sat_q <= ye_sat;
            end else if (state_q == ST_PH1) begin
                vld_q <= 1'b1;
                dat_q <= x_q[1];
            end
            if (accept) begin
                x_q[0] <= dat_in;
                x_q[1] <= x_q[0];
                x_q[2] <= x_q[1];
                x_q[3] <= x_q[2];
            end
            if (clk_vld_in && !in_rdy) drop_q <= 1'b1;
        end
    end

    assign clk_vld_out = vld_q;
    assign dat_out     = dat_q;
    assign sat_flag    = sat_q;
    assign drop_err    = drop_q;
endmodule

// File: tb/tb_hb_interp_filter.sv
// Directed and random checks of hb_interp_filter against hand values and a wide-precision model.
module tb_hb_interp_filter;
    localparam int DW = 35;
    localparam logic signed [DW-1:0] ONE30 = 35'sd1073741824;
    localparam logic signed [DW-1:0] PMAX  = 35'sd17179869183;
    localparam logic signed [DW-1:0] NMIN  = -35'sd17179869184;

    typedef struct {
        logic signed [DW-1:0] din;
        logic signed [DW-1:0] ev;
        logic signed [DW-1:0] od;
    } vec_t;

    logic clk = 1'b0;
    logic rst, clk_vld_in, in_rdy, clk_vld_out, drop_err, sat_flag;
    logic [DW-1:0] dat_in, dat_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic signed [DW-1:0] obs_d[$];
    bit                   obs_s[$];
    int                   obs_t[$];
    logic signed [DW-1:0] exp_d[$];
    bit                   exp_s[$];
    logic signed [DW-1:0] mx[4];
    vec_t imp[6];

    hb_interp_filter dut (
        .clk(clk), .rst(rst), .clk_vld_in(clk_vld_in), .dat_in(dat_in),
        .in_rdy(in_rdy), .clk_vld_out(clk_vld_out), .dat_out(dat_out),
        .drop_err(drop_err), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (clk_vld_out) begin
            obs_d.push_back(dat_out);
            obs_s.push_back(sat_flag);
            obs_t.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        obs_d.delete(); obs_s.delete(); obs_t.delete();
        exp_d.delete(); exp_s.delete();
        for (int i = 0; i < 4; i++) mx[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_vld_in = 1'b0; dat_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    // Called at a negedge; strobes one cycle, returns after gap cycles.
    task automatic send(input logic signed [DW-1:0] v, input int gap);
        mx[3] = mx[2]; mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = v;
        clk_vld_in = 1'b1; dat_in = v;
        @(negedge clk);
        clk_vld_in = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    function automatic void model_even(output logic signed [DW-1:0] y, output bit s);
        logic signed [79:0] k0, k1, acc, full;
        k0 = 80'sd54357298;
        k1 = 80'sd316817548;
        acc = k1 * (80'(mx[1]) + 80'(mx[2])) - k0 * (80'(mx[0]) + 80'(mx[3]));
        full = (acc <<< 1) >>> 30;
        y = full[DW-1:0];
        s = 1'b0;
`ifdef HB_INTERP_SAT_EN
        if (full > 80'sd17179869183) begin y = PMAX; s = 1'b1; end
        else if (full < -80'sd17179869184) begin y = NMIN; s = 1'b1; end
`endif
    endfunction

    task automatic cmp_all(input string nm);
        int n;
        chk({nm, "_count"}, obs_d.size(), exp_d.size());
        n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_dat[%0d]", nm, i), obs_d[i], exp_d[i]);
            chk($sformatf("%s_sat[%0d]", nm, i), 64'(obs_s[i]), 64'(exp_s[i]));
        end
    endtask

    task automatic run_impulse(input string nm);
        int breaks;
        for (int i = 0; i < 6; i++) begin
            send(imp[i].din, 2);
            exp_d.push_back(imp[i].ev); exp_s.push_back(1'b0);
            exp_d.push_back(imp[i].od); exp_s.push_back(1'b0);
        end
        repeat (5) @(negedge clk);
        cmp_all(nm);
        breaks = 0;
        for (int i = 1; i < obs_t.size(); i++) if (obs_t[i] - obs_t[i-1] != 1) breaks++;
        chk({nm, "_vld_gaps"}, breaks, 0);
    endtask

    initial begin
        logic signed [DW-1:0] e, r;
        bit s;
        int gaps;

        imp[0] = '{ONE30, -35'sd108714596, 35'sd0};
        imp[1] = '{35'sd0, 35'sd633635096, ONE30};
        imp[2] = '{35'sd0, 35'sd633635096, 35'sd0};
        imp[3] = '{35'sd0, -35'sd108714596, 35'sd0};
        imp[4] = '{35'sd0, 35'sd0, 35'sd0};
        imp[5] = '{35'sd0, 35'sd0, 35'sd0};

        // reset values
        do_reset();
        chk("rst_in_rdy", 64'(in_rdy), 1);
        chk("rst_vld", 64'(clk_vld_out), 0);
        chk("rst_dat", $signed(dat_out), 0);
        chk("rst_drop", 64'(drop_err), 0);
        chk("rst_sat", 64'(sat_flag), 0);

        // impulse at minimum spacing
        run_impulse("impulse");

        // DC at spacing 3
        do_reset();
        for (int i = 0; i < 6; i++) send(ONE30, 3);
        repeat (4) @(negedge clk);
        chk("dc_count", obs_d.size(), 12);
        if (obs_d.size() == 12) begin
            for (int i = 6; i < 12; i += 2) begin
                chk($sformatf("dc_even[%0d]", i), obs_d[i], 35'sd1049841000);
                chk($sformatf("dc_odd[%0d]", i), obs_d[i+1], ONE30);
            end
            gaps = 0;
            for (int i = 1; i < 12; i++) if (obs_t[i] - obs_t[i-1] != ((i % 2 == 1) ? 1 : 2)) gaps++;
            chk("dc_vld_pattern", gaps, 0);
        end

        // back-to-back strobes: second one dropped
        do_reset();
        clk_vld_in = 1'b1; dat_in = ONE30;
        @(negedge clk);
        chk("drop_in_rdy_ph0", 64'(in_rdy), 0);
        dat_in = 35'sd5;
        @(negedge clk);
        clk_vld_in = 1'b0;
        chk("drop_err_set", 64'(drop_err), 1);
        mx[0] = ONE30;
        send(35'sd0, 2);
        send(35'sd0, 2);
        repeat (4) @(negedge clk);
        exp_d = '{-35'sd108714596, 35'sd0, 35'sd633635096, ONE30, 35'sd633635096, 35'sd0};
        exp_s = '{0, 0, 0, 0, 0, 0};
        cmp_all("drop");
        chk("drop_err_sticky", 64'(drop_err), 1);

        // extreme inputs on the even path
        do_reset();
        send(NMIN, 2); send(PMAX, 2); send(PMAX, 2); send(NMIN, 2);
        repeat (4) @(negedge clk);
        chk("sat_count", obs_d.size(), 8);
        if (obs_d.size() == 8) begin
`ifdef HB_INTERP_SAT_EN
            chk("sat_even4", obs_d[6], PMAX);
            chk("sat_flag4", 64'(obs_s[6]), 1);
`else
            chk("wrap_even4", obs_d[6], -35'sd10604548226);
            chk("wrap_flag4", 64'(obs_s[6]), 0);
`endif
            chk("sat_odd4", obs_d[7], PMAX);
            chk("sat_odd4_flag", 64'(obs_s[7]), 0);
        end

        // reset between even and odd output
        do_reset();
        send(ONE30, 1);
        for (int k = 0; k < 6 && obs_d.size() == 0; k++) begin
            @(negedge clk); #1;
        end
        chk("rstmid_even_seen", obs_d.size(), 1);
        if (obs_d.size() > 0) chk("rstmid_even_val", obs_d[0], -35'sd108714596);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_vld", 64'(clk_vld_out), 0);
        chk("rstmid_dat", $signed(dat_out), 0);
        chk("rstmid_in_rdy", 64'(in_rdy), 1);
        rst = 1'b0;
        clear_q();
        run_impulse("post_rst_impulse");

        // random samples, random spacing against the model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            r = DW'({$urandom(), $urandom()});
            send(r, int'($urandom_range(2, 4)));
            model_even(e, s);
            exp_d.push_back(e);     exp_s.push_back(s);
            exp_d.push_back(mx[1]); exp_s.push_back(1'b0);
        end
        repeat (6) @(negedge clk);
        cmp_all("random");
        chk("random_pulses", obs_d.size(), 80);
        chk("random_no_drop", 64'(drop_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
